// File: rtl/arbiter_requester.sv
// Requester-side agent for a priority arbiter: turns a START/LEN job into a
// held request line, counts granted beats (surviving preemption), aborts if
// the grant never arrives, and forces an idle gap after every release.
module arbiter_requester #(
  parameter int BURST_W = 4,
  parameter int TIMEOUT = 15,
  parameter int GAP     = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [BURST_W-1:0] len_i,
  input  logic               gnt_i,
  output logic               req_o,
  output logic               beat_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               tout_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  // With no gap configured the release goes straight back to IDLE.
  localparam state_e             END_S    = (GAP == 0) ? S_IDLE : S_HOLD;
  localparam logic [7:0]         TO_C     = 8'(TIMEOUT);
  localparam logic [3:0]         GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
  localparam logic [BURST_W-1:0] REM_ONE  = BURST_W'(1);
  localparam logic [BURST_W-1:0] REM_ZERO = BURST_W'(0);

  state_e             state_q, state_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [7:0]         wcnt_q, wcnt_d;
  logic [3:0]         gcnt_q, gcnt_d;
  logic               done_q, done_d;
  logic               tout_q, tout_d;
  logic [7:0]         wcnt_inc_s;

  assign wcnt_inc_s = wcnt_q + 8'd1;

  // Next-state and counter updates; pulses are computed here and registered.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    wcnt_d  = wcnt_q;
    gcnt_d  = gcnt_q;
    done_d  = 1'b0;
    tout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && (len_i != REM_ZERO)) begin
          state_d = S_WAIT;
          rem_d   = len_i;
          wcnt_d  = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (gnt_i) begin
          state_d = S_XFER;
        end else begin
          wcnt_d = wcnt_inc_s;
          if (wcnt_inc_s == TO_C) begin
            state_d = END_S;
            gcnt_d  = 4'd0;
            tout_d  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_XFER: begin
        if (gnt_i) begin
          if (rem_q == REM_ONE) begin
            rem_d   = REM_ZERO;
            state_d = END_S;
            gcnt_d  = 4'd0;
            done_d  = 1'b1;
          end else begin
            rem_d = rem_q - REM_ONE;
          end
        end else begin
          // Preempted: hold the request and the remaining count.
          state_d = S_XFER;
        end
      end
      S_HOLD: begin
        if (gcnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and pulse registers; async reset returns to a clean IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      rem_q   <= REM_ZERO;
      wcnt_q  <= 8'd0;
      gcnt_q  <= 4'd0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wcnt_q  <= wcnt_d;
      gcnt_q  <= gcnt_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
    end
  end

  assign req_o  = (state_q == S_WAIT) || (state_q == S_XFER);
  assign busy_o = (state_q != S_IDLE);
  assign beat_o = (state_q == S_XFER) && gnt_i;
  assign done_o = done_q;
  assign tout_o = tout_q;

endmodule

// File: tb/tb_arbiter_requester.sv
// Bench for arbiter_requester: directed vector table, hand-written corner
// sequences, and a randomized run against a job-timeline reference model.
module tb_arbiter_requester;

  localparam int N = 1200;
  localparam logic [4:0] M_REQ  = 5'b10000;
  localparam logic [4:0] M_BEAT = 5'b01000;
  localparam logic [4:0] M_BUSY = 5'b00100;
  localparam logic [4:0] M_DONE = 5'b00010;
  localparam logic [4:0] M_TOUT = 5'b00001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] len = 4'd0;
  logic       gnt = 1'b0;
  logic       req0, beat0, busy0, done0, tout0;
  logic       req1, beat1, busy1, done1, tout1;
  logic [4:0] o0, o1;

  int tests = 0;
  int fails = 0;

  // Outputs packed as {req, beat, busy, done, tout}.
  assign o0 = {req0, beat0, busy0, done0, tout0};
  assign o1 = {req1, beat1, busy1, done1, tout1};

  always #5 clk = ~clk;

  arbiter_requester #(.BURST_W(4), .TIMEOUT(15), .GAP(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .len_i(len), .gnt_i(gnt),
    .req_o(req0), .beat_o(beat0), .busy_o(busy0), .done_o(done0), .tout_o(tout0)
  );

  arbiter_requester #(.BURST_W(4), .TIMEOUT(3), .GAP(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .len_i(len), .gnt_i(gnt),
    .req_o(req1), .beat_o(beat1), .busy_o(busy1), .done_o(done1), .tout_o(tout1)
  );

  typedef struct {
    logic       s;
    logic [3:0] l;
    logic       g;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl [19];

  logic       st_start [N];
  logic [3:0] st_len   [N];
  logic       st_gnt   [N];
  logic [4:0] exp_o    [2][N];

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {req,beat,busy,done,tout}=%b, expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then settle before sampling.
  task automatic drive(input logic s, input logic [3:0] l, input logic g);
    @(negedge clk);
    start = s;
    len   = l;
    gnt   = g;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    len   = 4'd0;
    gnt   = 1'b0;
    #1;
    chk("reset_dut", o0, 5'b00000);
    chk("reset_dut0", o1, 5'b00000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: walks the stimulus as a sequence of jobs. A job accepted
  // at cycle c requests from c+1, waits until a grant or 'to' ungranted cycles,
  // then requests until LEN granted cycles have passed. The pulse lands in the
  // cycle after the last active cycle, followed by 'gap' busy cycles.
  task automatic build_model(input int inst, input int to, input int gap);
    int c, m, w, beats;
    bit granted;
    for (int i = 0; i < N; i++) exp_o[inst][i] = 5'b00000;
    c = 0;
    while (c < N) begin
      if (st_start[c] && (st_len[c] != 4'd0)) begin
        m = c + 1;
        w = 0;
        granted = 1'b0;
        while ((m < N) && !granted && (w < to)) begin
          exp_o[inst][m] = exp_o[inst][m] | M_REQ | M_BUSY;
          if (st_gnt[m]) granted = 1'b1;
          else w++;
          m++;
        end
        if (granted) begin
          beats = 0;
          while ((m < N) && (beats < int'(st_len[c]))) begin
            exp_o[inst][m] = exp_o[inst][m] | M_REQ | M_BUSY;
            if (st_gnt[m]) begin
              exp_o[inst][m] = exp_o[inst][m] | M_BEAT;
              beats++;
            end
            m++;
          end
        end
        if (m < N) exp_o[inst][m] = exp_o[inst][m] | (granted ? M_DONE : M_TOUT);
        for (int g = 0; g < gap; g++) begin
          if (m + g < N) exp_o[inst][m + g] = exp_o[inst][m + g] | M_BUSY;
        end
        c = m + gap;
      end else begin
        c++;
      end
    end
  endtask

  initial begin
    // Basic LEN=3 burst, preempted LEN=4 burst, START in HOLD and LEN=0 ignored.
    tbl[0]  = '{1'b1, 4'd3, 1'b0, 5'b00000};
    tbl[1]  = '{1'b0, 4'd0, 1'b1, 5'b10100};
    tbl[2]  = '{1'b0, 4'd0, 1'b1, 5'b11100};
    tbl[3]  = '{1'b0, 4'd0, 1'b1, 5'b11100};
    tbl[4]  = '{1'b0, 4'd0, 1'b1, 5'b11100};
    tbl[5]  = '{1'b1, 4'd2, 1'b0, 5'b00110};
    tbl[6]  = '{1'b0, 4'd0, 1'b1, 5'b00000};
    tbl[7]  = '{1'b1, 4'd4, 1'b0, 5'b00000};
    tbl[8]  = '{1'b0, 4'd0, 1'b1, 5'b10100};
    tbl[9]  = '{1'b0, 4'd0, 1'b1, 5'b11100};
    tbl[10] = '{1'b0, 4'd0, 1'b0, 5'b10100};
    tbl[11] = '{1'b0, 4'd0, 1'b0, 5'b10100};
    tbl[12] = '{1'b0, 4'd0, 1'b1, 5'b11100};
    tbl[13] = '{1'b0, 4'd0, 1'b1, 5'b11100};
    tbl[14] = '{1'b0, 4'd0, 1'b0, 5'b10100};
    tbl[15] = '{1'b0, 4'd0, 1'b1, 5'b11100};
    tbl[16] = '{1'b0, 4'd0, 1'b0, 5'b00110};
    tbl[17] = '{1'b1, 4'd0, 1'b1, 5'b00000};
    tbl[18] = '{1'b0, 4'd0, 1'b0, 5'b00000};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].s, tbl[i].l, tbl[i].g);
      chk($sformatf("vec%0d", i), o0, tbl[i].exp);
    end

    // Timeout: no grant for 15 WAIT cycles, START during HOLD ignored.
    do_reset();
    drive(1'b1, 4'd2, 1'b0);
    chk("to_start", o0, 5'b00000);
    for (int k = 1; k <= 15; k++) begin
      drive(1'b0, 4'd0, 1'b0);
      chk($sformatf("to_wait%0d", k), o0, 5'b10100);
    end
    drive(1'b1, 4'd3, 1'b0);
    chk("to_pulse", o0, 5'b00101);
    drive(1'b0, 4'd0, 1'b0);
    chk("to_idle", o0, 5'b00000);
    drive(1'b0, 4'd0, 1'b0);
    chk("to_hold_start_ignored", o0, 5'b00000);

    // Timeout boundary: grant in WAIT cycle 15 still wins.
    do_reset();
    drive(1'b1, 4'd1, 1'b0);
    chk("tb_start", o0, 5'b00000);
    for (int k = 1; k <= 14; k++) begin
      drive(1'b0, 4'd0, 1'b0);
      chk($sformatf("tb_wait%0d", k), o0, 5'b10100);
    end
    drive(1'b0, 4'd0, 1'b1);
    chk("tb_grant15", o0, 5'b10100);
    drive(1'b0, 4'd0, 1'b1);
    chk("tb_beat", o0, 5'b11100);
    drive(1'b0, 4'd0, 1'b0);
    chk("tb_done", o0, 5'b00110);

    // Reset during beat 2 of a LEN=5 burst.
    do_reset();
    drive(1'b1, 4'd5, 1'b0);
    drive(1'b0, 4'd0, 1'b1);
    chk("rst_wait", o0, 5'b10100);
    drive(1'b0, 4'd0, 1'b1);
    chk("rst_beat1", o0, 5'b11100);
    drive(1'b0, 4'd0, 1'b1);
    chk("rst_beat2", o0, 5'b11100);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_xfer", o0, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'd0, 1'b1);
      chk($sformatf("rst_after%0d", k), o0, 5'b00000);
    end

    // GAP=0 instance: restart on the DONE cycle, then a TIMEOUT=3 abort.
    do_reset();
    drive(1'b1, 4'd2, 1'b0);
    chk("g0_start", o1, 5'b00000);
    drive(1'b0, 4'd0, 1'b1);
    chk("g0_wait", o1, 5'b10100);
    drive(1'b0, 4'd0, 1'b1);
    chk("g0_beat1", o1, 5'b11100);
    drive(1'b0, 4'd0, 1'b1);
    chk("g0_beat2", o1, 5'b11100);
    drive(1'b1, 4'd1, 1'b0);
    chk("g0_done_idle", o1, 5'b00010);
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 4'd0, 1'b0);
      chk($sformatf("g0_rewait%0d", k), o1, 5'b10100);
    end
    drive(1'b0, 4'd0, 1'b0);
    chk("g0_tout", o1, 5'b00001);

    // Randomized run; grant density varies per block to reach timeouts.
    for (int c = 0; c < N; c++) begin
      int thr;
      case ((c / 100) % 4)
        0: thr = 9;
        1: thr = 6;
        2: thr = 2;
        default: thr = 0;
      endcase
      st_start[c] = ($urandom_range(0, 3) != 0);
      st_len[c]   = 4'($urandom_range(0, 15));
      st_gnt[c]   = (int'($urandom_range(0, 9)) < thr);
    end
    build_model(0, 15, 1);
    build_model(1, 3, 0);
    do_reset();
    for (int c = 0; c < N; c++) begin
      drive(st_start[c], st_len[c], st_gnt[c]);
      chk($sformatf("rand_dut_c%0d", c), o0, exp_o[0][c]);
      chk($sformatf("rand_dut0_c%0d", c), o1, exp_o[1][c]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
